// File: rtl/hdc_pkg.sv
// Shared definitions for the HDC seizure-detection similarity path.
//   HDC_DIMENSIONS : default hypervector width in bits
//   label_e        : classifier result encoding
//   state_e        : sequencer states
//   dist_width()   : bits needed to hold a Hamming distance of 0..dims
package hdc_pkg;

  localparam int HDC_DIMENSIONS = 10000;

  typedef enum logic {
    LBL_NONSEIZURE = 1'b0,
    LBL_SEIZURE    = 1'b1
  } label_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int dist_width(input int dims);
    return $clog2(dims + 1);
  endfunction

endpackage

// File: rtl/hdc_popcount.sv
// Combinational population count.
//   vec   : W-bit input vector
//   count : number of ones in vec, $clog2(W+1) bits
module hdc_popcount #(
  parameter int W = 8
) (
  input  logic [W-1:0]           vec,
  output logic [$clog2(W+1)-1:0] count
);

  localparam int CNTW = $clog2(W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CNTW'(vec[i]);
    end
  end

endmodule

// File: rtl/similarity_seq_ctrl.sv
// Sequenced Hamming-distance classifier. A query hypervector is captured on
// the hv handshake, then compared against the non-seizure and seizure class
// hypervectors CHUNK bits per cycle over DIMENSIONS/CHUNK cycles. The result
// (two distances and a label) is presented with valid/ready and held until
// accepted.
//   clk, rst_n               : clock, synchronous active-low reset
//   hv_valid/hv_ready/hv     : query input handshake and data
//   ns_hv, s_hv              : class hypervectors, stable while busy
//   label_valid/label_ready  : result handshake
//   label_out                : 0 = non-seizure, 1 = seizure (tie -> 1)
//   dist_ns, dist_s          : Hamming distances to ns_hv / s_hv
//   busy                     : comparison in progress or result pending
module similarity_seq_ctrl
  import hdc_pkg::*;
#(
  parameter int DIMENSIONS = HDC_DIMENSIONS,
  parameter int CHUNK      = 500
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              hv_valid,
  output logic                              hv_ready,
  input  logic [DIMENSIONS-1:0]             hv,
  input  logic [DIMENSIONS-1:0]             ns_hv,
  input  logic [DIMENSIONS-1:0]             s_hv,
  output logic                              label_valid,
  input  logic                              label_ready,
  output logic                              label_out,
  output logic [dist_width(DIMENSIONS)-1:0] dist_ns,
  output logic [dist_width(DIMENSIONS)-1:0] dist_s,
  output logic                              busy
);

  localparam int NCHUNK = DIMENSIONS / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW     = dist_width(DIMENSIONS);
  localparam int PW     = $clog2(CHUNK + 1);

  if (DIMENSIONS % CHUNK != 0) begin : g_bad_chunk
    $error("similarity_seq_ctrl: DIMENSIONS must be a multiple of CHUNK");
  end

  state_e              state_reg, state_next;
  logic [DIMENSIONS-1:0] q_reg;
  logic [IW-1:0]       idx_reg;
  logic [CW-1:0]       acc_ns_reg, acc_s_reg;
  logic [CW-1:0]       dist_ns_reg, dist_s_reg;
  label_e              label_reg;

  // Slice the three vectors into CHUNK-wide words so the active chunk is a
  // simple array lookup by idx_reg.
  logic [CHUNK-1:0] q_chunk  [NCHUNK];
  logic [CHUNK-1:0] ns_chunk [NCHUNK];
  logic [CHUNK-1:0] s_chunk  [NCHUNK];

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
    assign q_chunk[gi]  = q_reg[gi*CHUNK +: CHUNK];
    assign ns_chunk[gi] = ns_hv[gi*CHUNK +: CHUNK];
    assign s_chunk[gi]  = s_hv[gi*CHUNK +: CHUNK];
  end

  logic [CHUNK-1:0] diff_ns, diff_s;
  logic [PW-1:0]    pc_ns, pc_s;
  logic [CW-1:0]    acc_ns_sum, acc_s_sum;
  logic             last_chunk;

  assign diff_ns = q_chunk[idx_reg] ^ ns_chunk[idx_reg];
  assign diff_s  = q_chunk[idx_reg] ^ s_chunk[idx_reg];

  hdc_popcount #(.W(CHUNK)) u_pc_ns (.vec(diff_ns), .count(pc_ns));
  hdc_popcount #(.W(CHUNK)) u_pc_s  (.vec(diff_s),  .count(pc_s));

  assign acc_ns_sum = acc_ns_reg + CW'(pc_ns);
  assign acc_s_sum  = acc_s_reg  + CW'(pc_s);
  assign last_chunk = (idx_reg == IW'(NCHUNK - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; hv_ready is high only in IDLE so hv_valid alone
  // qualifies the handshake there.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (hv_valid)    state_next = ACCUM;
      ACCUM:   if (last_chunk)  state_next = DONE;
      DONE:    if (label_ready) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    hv_ready    = 1'b0;
    busy        = 1'b0;
    label_valid = 1'b0;
    case (state_reg)
      IDLE:    hv_ready = 1'b1;
      ACCUM:   busy     = 1'b1;
      DONE: begin
        busy        = 1'b1;
        label_valid = 1'b1;
      end
      default: hv_ready = 1'b0;
    endcase
  end

  // Query capture; no reset needed since it is always loaded before use.
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && hv_valid) begin
      q_reg <= hv;
    end
  end

  // Accumulation and result registers. The result is loaded on the final
  // ACCUM cycle from the running sum so it is valid on entry to DONE, and it
  // is left untouched afterwards so it persists through IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_reg     <= '0;
      acc_ns_reg  <= '0;
      acc_s_reg   <= '0;
      dist_ns_reg <= '0;
      dist_s_reg  <= '0;
      label_reg   <= LBL_NONSEIZURE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hv_valid) begin
            idx_reg    <= '0;
            acc_ns_reg <= '0;
            acc_s_reg  <= '0;
          end
        end
        ACCUM: begin
          acc_ns_reg <= acc_ns_sum;
          acc_s_reg  <= acc_s_sum;
          idx_reg    <= idx_reg + 1'b1;
          if (last_chunk) begin
            dist_ns_reg <= acc_ns_sum;
            dist_s_reg  <= acc_s_sum;
            label_reg   <= (acc_ns_sum < acc_s_sum) ? LBL_NONSEIZURE : LBL_SEIZURE;
          end
        end
        default: ;
      endcase
    end
  end

  assign dist_ns   = dist_ns_reg;
  assign dist_s    = dist_s_reg;
  assign label_out = label_reg;

endmodule

// File: tb/tb_similarity_seq_ctrl.sv
// Bench for similarity_seq_ctrl: a small instance (16/4) for directed
// scenarios and a full-size instance (10000/500) for randomized queries.
// Expected results are queued at the input handshake and checked by a
// monitor whenever a new label_valid appears.
module tb_similarity_seq_ctrl;

  localparam int DS = 16,    CS = 4,   NS = DS / CS;
  localparam int DL = 10000, CL = 500, NL = DL / CL;

  typedef struct {
    int dns;
    int ds;
    int lbl;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   rnd_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // small instance
  logic          sa_hv_valid = 1'b0, sa_hv_ready, sa_label_valid;
  logic          sa_label_ready = 1'b1, sa_label_out, sa_busy;
  logic [DS-1:0] sa_hv = '0, sa_ns = '0, sa_s = '0;
  logic [4:0]    sa_dns, sa_ds;

  // full-size instance
  logic          lg_hv_valid = 1'b0, lg_hv_ready, lg_label_valid;
  logic          lg_label_ready, lg_label_out, lg_busy;
  logic [DL-1:0] lg_hv = '0, lg_ns = '0, lg_s = '0;
  logic [13:0]   lg_dns, lg_ds;

  similarity_seq_ctrl #(.DIMENSIONS(DS), .CHUNK(CS)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .hv_valid(sa_hv_valid), .hv_ready(sa_hv_ready), .hv(sa_hv),
    .ns_hv(sa_ns), .s_hv(sa_s),
    .label_valid(sa_label_valid), .label_ready(sa_label_ready),
    .label_out(sa_label_out), .dist_ns(sa_dns), .dist_s(sa_ds),
    .busy(sa_busy)
  );

  similarity_seq_ctrl #(.DIMENSIONS(DL), .CHUNK(CL)) dut_large (
    .clk(clk), .rst_n(rst_n),
    .hv_valid(lg_hv_valid), .hv_ready(lg_hv_ready), .hv(lg_hv),
    .ns_hv(lg_ns), .s_hv(lg_s),
    .label_valid(lg_label_valid), .label_ready(lg_label_ready),
    .label_out(lg_label_out), .dist_ns(lg_dns), .dist_s(lg_ds),
    .busy(lg_busy)
  );

  exp_t q0[$];
  exp_t q1[$];
  bit   checked[2];
  exp_t last_e[2];

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Scoreboard monitor: the first cycle of each label_valid pops the next
  // expected result; later cycles of the same result must hold steady.
  task automatic mon(input int d, input logic lv, input logic hr,
                     input int dns, input int ds, input int lo);
    exp_t e;
    bit   ok;
    string tag;
    tag = (d == 0) ? "small" : "large";
    if (!lv) begin
      checked[d] = 1'b0;
    end else if (!checked[d]) begin
      ok = 1'b0;
      if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      checked[d] = 1'b1;
      if (!ok) begin
        timeout_fail({tag, " unexpected label_valid (no query pending)"});
        e.dns = dns; e.ds = ds; e.lbl = lo; e.cyc = cyc;
      end else begin
        $display("[TB] %s result @%0d: dist_ns=%0d/%0d dist_s=%0d/%0d label=%0d/%0d",
                 tag, cyc, dns, e.dns, ds, e.ds, lo, e.lbl);
        chk({tag, " dist_ns"}, dns, e.dns);
        chk({tag, " dist_s"}, ds, e.ds);
        chk({tag, " label_out"}, lo, e.lbl);
        chk({tag, " latency cycle"}, cyc, e.cyc);
      end
      last_e[d] = e;
    end else begin
      chk({tag, " held dist_ns"}, dns, last_e[d].dns);
      chk({tag, " held dist_s"}, ds, last_e[d].ds);
      chk({tag, " held label_out"}, lo, last_e[d].lbl);
      chk({tag, " hv_ready while label_valid"}, int'(hr), 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, sa_label_valid, sa_hv_ready, int'(sa_dns), int'(sa_ds), int'(sa_label_out));
      mon(1, lg_label_valid, lg_hv_ready, int'(lg_dns), int'(lg_ds), int'(lg_label_out));
    end
  end

  // Random backpressure on the large instance during the random phase.
  initial begin
    lg_label_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      lg_label_ready = rnd_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic ready_of(input int d);
    return (d == 0) ? sa_hv_ready : lg_hv_ready;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? sa_busy : lg_busy;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Offer a query once the DUT is idle; the expected result comes straight
  // from the Hamming-distance definition.
  task automatic send(input int d, input logic [DL-1:0] h,
                      input logic [DL-1:0] n, input logic [DL-1:0] s);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ready_of(d)) begin got = 1'b1; break; end
    end
    if (!got) begin
      timeout_fail("hv_ready");
      return;
    end
    if (d == 0) begin
      sa_hv = h[DS-1:0]; sa_ns = n[DS-1:0]; sa_s = s[DS-1:0]; sa_hv_valid = 1'b1;
    end else begin
      lg_hv = h; lg_ns = n; lg_s = s; lg_hv_valid = 1'b1;
    end
    e.dns = $countones(h ^ n);
    e.ds  = $countones(h ^ s);
    e.lbl = (e.dns < e.ds) ? 0 : 1;
    e.cyc = cyc + ((d == 0) ? NS : NL) + 1;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk);
    #1;
    if (d == 0) sa_hv_valid = 1'b0; else lg_hv_valid = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (qsize(d) == 0 && !busy_of(d)) begin done = 1'b1; break; end
    end
    if (!done) timeout_fail("result drain");
  endtask

  task automatic chk_reset_small(input string tag);
    chk({tag, " hv_ready"}, int'(sa_hv_ready), 1);
    chk({tag, " label_valid"}, int'(sa_label_valid), 0);
    chk({tag, " label_out"}, int'(sa_label_out), 0);
    chk({tag, " dist_ns"}, int'(sa_dns), 0);
    chk({tag, " dist_s"}, int'(sa_ds), 0);
    chk({tag, " busy"}, int'(sa_busy), 0);
  endtask

  task automatic rand_vec(output logic [DL-1:0] v);
    logic [31:0] w;
    v = '0;
    for (int i = 0; i < DL; i += 32) begin
      w = $urandom;
      for (int j = 0; j < 32; j++) begin
        if (i + j < DL) v[i + j] = w[j];
      end
    end
  endtask

  initial begin
    logic [DL-1:0] h, n, s;
    bit seen;

    // reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset_small("reset small");
    chk("reset large hv_ready", int'(lg_hv_ready), 1);
    chk("reset large label_valid", int'(lg_label_valid), 0);
    chk("reset large dist_ns", int'(lg_dns), 0);
    chk("reset large busy", int'(lg_busy), 0);

    // basic non-seizure result
    send(0, DL'(16'h00FF), DL'(16'h00FF), DL'(16'hFF00));
    wait_idle(0, 100);

    // tie resolves to seizure
    send(0, DL'(16'h000F), DL'(16'h00F0), DL'(16'hF000));
    wait_idle(0, 100);

    // query changes after capture have no effect
    send(0, DL'(16'h00FF), DL'(16'h00FF), DL'(16'hFF00));
    sa_hv = 16'hFFFF;
    wait_idle(0, 100);

    // backpressure: result held, extra hv_valid ignored
    sa_label_ready = 1'b0;
    send(0, DL'(16'hAAAA), DL'(16'h5555), DL'(16'hAAAB));
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sa_label_valid) begin seen = 1'b1; break; end
    end
    if (!seen) timeout_fail("backpressure label_valid");
    sa_hv = 16'h0000;
    sa_hv_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp busy", int'(sa_busy), 1);
      chk("bp label_valid", int'(sa_label_valid), 1);
    end
    sa_hv_valid = 1'b0;
    sa_label_ready = 1'b1;
    @(negedge clk);
    chk("post-bp hv_ready", int'(sa_hv_ready), 1);
    chk("post-bp label_valid", int'(sa_label_valid), 0);
    chk("post-bp busy", int'(sa_busy), 0);
    chk("post-bp label_out kept", int'(sa_label_out), 1);
    chk("post-bp dist_ns kept", int'(sa_dns), 16);
    chk("post-bp dist_s kept", int'(sa_ds), 1);

    // reset in the middle of ACCUM discards the query
    send(0, DL'(16'h1234), DL'(16'h0F0F), DL'(16'hFFFF));
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    q0.delete();
    q1.delete();
    checked[0] = 1'b0;
    checked[1] = 1'b0;
    @(negedge clk);
    chk_reset_small("mid-accum reset");
    send(0, DL'(16'h0F0F), DL'(16'h0FF0), DL'(16'h0F00));
    wait_idle(0, 100);

    // randomized queries on the full-size instance
    rnd_on = 1'b1;
    for (int k = 0; k < 200; k++) begin
      rand_vec(h);
      rand_vec(n);
      rand_vec(s);
      send(1, h, n, s);
    end
    wait_idle(1, 3000);
    rnd_on = 1'b0;

    chk("small leftover expected", q0.size(), 0);
    chk("large leftover expected", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
